// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: fun3 load/store encodings and the MEM-stage FSM state type.
package riscv_pkg;

    localparam logic [2:0] Funct3Byte   = 3'b000;  // LB / SB
    localparam logic [2:0] Funct3Half   = 3'b001;  // LH / SH
    localparam logic [2:0] Funct3Word   = 3'b010;  // LW / SW
    localparam logic [2:0] Funct3ByteU  = 3'b100;  // LBU
    localparam logic [2:0] Funct3HalfU  = 3'b101;  // LHU

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } mau_state_e;

endpackage

// File: rtl/mem_load_format.sv
// Selects the addressed lane of a read word and sign- or zero-extends it.
module mem_load_format
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  fun3,
    output logic [31:0] result
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Lane selection by byte offset; halfwords use offset[1] only
    always_comb begin
        lane_byte = rdata[8*offset +: 8];
        lane_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension by access size and signedness; illegal codes yield zero
    always_comb begin
        result = '0;
        case (fun3)
            Funct3Byte:  result = {{24{lane_byte[7]}}, lane_byte};
            Funct3Half:  result = {{16{lane_half[15]}}, lane_half};
            Funct3Word:  result = rdata;
            Funct3ByteU: result = {24'h0, lane_byte};
            Funct3HalfU: result = {16'h0, lane_half};
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: runs one req/ack bus transaction per memory
// instruction, stalls the pipeline while it is outstanding, and formats load data.
module mem_access_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemR,
    input  logic        MemW,
    input  logic [2:0]  fun3,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    mau_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      offset_q;
    logic [2:0]      fun3_q;
    logic            is_load_q;
    logic            tmo_q;

    logic        access;
    logic        fun3_ok;
    logic        misaligned;
    logic        req_fault;
    logic        start;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_result;

    // Request legality check, only meaningful while IDLE
    always_comb begin
        access = MemR | MemW;
        if (MemR) begin
            fun3_ok = (fun3 == Funct3Byte) || (fun3 == Funct3Half) || (fun3 == Funct3Word) ||
                      (fun3 == Funct3ByteU) || (fun3 == Funct3HalfU);
        end else begin
            fun3_ok = (fun3 == Funct3Byte) || (fun3 == Funct3Half) || (fun3 == Funct3Word);
        end
        misaligned = ((fun3[1:0] == 2'b01) && Addr[0]) || ((fun3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));
        req_fault  = access && ((MemR && MemW) || !fun3_ok || misaligned);
        start      = access && !req_fault;
    end

    // Byte enables and lane-replicated store data for the access size
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = WrData;
        case (fun3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << Addr[1:0];
                wdata_d = {4{WrData[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {Addr[1], 1'b0};
                wdata_d = {2{WrData[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = WrData;
            end
        endcase
    end

    // Stall and fault flags; gated by reset so every output clears while it is held
    always_comb begin
        mem_stall = reset_n && (((state_q == StIdle) && start) || (state_q == StReq));
        mem_fault = reset_n && (((state_q == StIdle) && req_fault) || ((state_q == StDone) && tmo_q));
    end

    mem_load_format u_load_format (
        .rdata  (dmem_rdata),
        .offset (offset_q),
        .fun3   (fun3_q),
        .result (load_result)
    );

    // Transaction FSM with registered bus outputs and load result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            offset_q   <= '0;
            fun3_q     <= '0;
            is_load_q  <= 1'b0;
            tmo_q      <= 1'b0;
            RdData     <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    tmo_q <= 1'b0;
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemW;
                        dmem_addr  <= {Addr[31:2], 2'b00};
                        dmem_be    <= be_d;
                        dmem_wdata <= wdata_d;
                        offset_q   <= Addr[1:0];
                        fun3_q     <= fun3;
                        is_load_q  <= MemR;
                        cnt_q      <= '0;
                        state_q    <= StReq;
                    end
                end
                StReq: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (is_load_q) begin
                            RdData <= load_result;
                        end
                        state_q <= StDone;
                    end else if (cnt_q == CntLast) begin
                        // Abort: the bus never answered
                        dmem_req <= 1'b0;
                        RdData   <= '0;
                        tmo_q    <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    // One idle cycle so the same EX/MEM access is not re-issued
                    tmo_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT = 4).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemR, MemW;
    logic [2:0]  fun3;
    logic [31:0] Addr, WrData;
    logic [31:0] RdData;
    logic        mem_stall, mem_fault;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int tests = 0;
    int fails = 0;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .MemR       (MemR),
        .MemW       (MemW),
        .fun3       (fun3),
        .Addr       (Addr),
        .WrData     (WrData),
        .RdData     (RdData),
        .mem_stall  (mem_stall),
        .mem_fault  (mem_fault),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    always #5 clk = ~clk;

    // Stimulus only: present an EX/MEM instruction
    task automatic drive(input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd);
        MemR = r; MemW = w; fun3 = f; Addr = a; WrData = wd;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        tests++;
        if ({RdData, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_stall, mem_fault} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rd=%h req=%b we=%b addr=%h be=%b wd=%h stall=%b fault=%b, want all 0",
                     RdData, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_stall, mem_fault);
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            fails++; $display("FAIL reset_idle: got req=%b stall=%b want 0 0", dmem_req, mem_stall);
        end
    endtask

    task automatic test_lw;
        drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        tests++;
        if (mem_stall !== 1'b1 || dmem_req !== 1'b0 || mem_fault !== 1'b0) begin
            fails++; $display("FAIL lw_idle: got stall=%b req=%b fault=%b want 1 0 0", mem_stall, dmem_req, mem_fault);
        end
        @(negedge clk);
        tests++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || dmem_be !== 4'b1111 || mem_stall !== 1'b1) begin
            fails++; $display("FAIL lw_req: got req=%b we=%b addr=%h be=%b stall=%b want 1 0 00000100 1111 1",
                              dmem_req, dmem_we, dmem_addr, dmem_be, mem_stall);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_ack = 1'b0;
        tests++;
        if (RdData !== 32'hDEAD_BEEF || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            fails++; $display("FAIL lw_done: got rd=%h req=%b stall=%b want deadbeef 0 0", RdData, dmem_req, mem_stall);
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        tests++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || RdData !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL lw_after: got req=%b stall=%b rd=%h want 0 0 deadbeef", dmem_req, mem_stall, RdData);
        end
    endtask

    task automatic test_lb_lbu;
        logic [2:0]  f3  [2] = '{3'b000, 3'b100};
        logic [31:0] exp [2] = '{32'hFFFF_FF80, 32'h0000_0080};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, f3[i], 32'h103, 32'h0);
            @(negedge clk);
            tests++;
            if (dmem_be !== 4'b1000 || dmem_addr !== 32'h100 || dmem_req !== 1'b1) begin
                fails++; $display("FAIL lb_req[%0d]: got be=%b addr=%h req=%b want 1000 00000100 1", i, dmem_be, dmem_addr, dmem_req);
            end
            dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FF7F;
            @(negedge clk);
            dmem_ack = 1'b0;
            tests++;
            if (RdData !== exp[i]) begin
                fails++; $display("FAIL lb_data[%0d]: got %h want %h", i, RdData, exp[i]);
            end
            drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_sh;
        drive(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD);
        @(negedge clk);
        tests++;
        if (dmem_we !== 1'b1 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD || dmem_addr !== 32'h200) begin
            fails++; $display("FAIL sh_bus: got we=%b be=%b wd=%h addr=%h want 1 1100 abcdabcd 00000200",
                              dmem_we, dmem_be, dmem_wdata, dmem_addr);
        end
        // One wait state: still requesting and stalled
        @(negedge clk);
        tests++;
        if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin
            fails++; $display("FAIL sh_wait: got req=%b stall=%b want 1 1", dmem_req, mem_stall);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        dmem_ack = 1'b0;
        tests++;
        if (RdData !== 32'h0000_0080 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            fails++; $display("FAIL sh_done: got rd=%h req=%b stall=%b want 00000080 0 0", RdData, dmem_req, mem_stall);
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_faults;
        // {MemR, MemW, fun3, Addr}
        logic [36:0] vec [6] = '{
            {1'b1, 1'b0, 3'b010, 32'h101},   // LW misaligned
            {1'b1, 1'b0, 3'b011, 32'h104},   // illegal load fun3
            {1'b1, 1'b0, 3'b001, 32'h103},   // LH odd address
            {1'b1, 1'b1, 3'b010, 32'h100},   // load and store together
            {1'b0, 1'b1, 3'b100, 32'h100},   // store with unsigned-load code
            {1'b0, 1'b1, 3'b010, 32'h102}    // SW misaligned
        };
        for (int i = 0; i < 6; i++) begin
            drive(vec[i][36], vec[i][35], vec[i][34:32], vec[i][31:0], 32'hCAFE_F00D);
            #1;
            tests++;
            if (mem_fault !== 1'b1 || mem_stall !== 1'b0) begin
                fails++; $display("FAIL fault_flag[%0d]: got fault=%b stall=%b want 1 0", i, mem_fault, mem_stall);
            end
            @(negedge clk);
            tests++;
            if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
                fails++; $display("FAIL fault_noreq[%0d]: got req=%b stall=%b want 0 0", i, dmem_req, mem_stall);
            end
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        tests++;
        if (mem_fault !== 1'b0) begin
            fails++; $display("FAIL fault_clear: got %b want 0", mem_fault);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int n = 0;
        drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dmem_req === 1'b1) n++;
            else break;
        end
        tests++;
        if (n != 4) begin
            fails++; $display("FAIL tmo_req_cycles: got %0d want 4", n);
        end
        tests++;
        if (mem_fault !== 1'b1 || RdData !== 32'h0 || mem_stall !== 1'b0) begin
            fails++; $display("FAIL tmo_done: got fault=%b rd=%h stall=%b want 1 00000000 0", mem_fault, RdData, mem_stall);
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        tests++;
        if (mem_fault !== 1'b0) begin
            fails++; $display("FAIL tmo_pulse: got fault=%b want 0", mem_fault);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        tests++;
        if (RdData !== 32'h0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            fails++; $display("FAIL tmo_late_ack: got rd=%h req=%b stall=%b want 00000000 0 0", RdData, dmem_req, mem_stall);
        end
    endtask

    task automatic test_reset_mid_req;
        drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        dmem_ack = 1'b0;
        tests++;
        if (RdData !== 32'h1234_5678) begin
            fails++; $display("FAIL rst_setup: got %h want 12345678", RdData);
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({RdData, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_stall, mem_fault} !== '0) begin
            fails++;
            $display("FAIL rst_mid_req: got rd=%h req=%b addr=%h be=%b stall=%b fault=%b want all 0",
                     RdData, dmem_req, dmem_addr, dmem_be, mem_stall, mem_fault);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_A5A5;
        reset_n = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        tests++;
        if (RdData !== 32'h0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            fails++; $display("FAIL rst_late_ack: got rd=%h req=%b stall=%b want 00000000 0 0", RdData, dmem_req, mem_stall);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_faults();
        test_timeout();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
